// File: rtl/baud_gen.sv
// baud_gen: 16x-oversample and bit-period tick generator for a UART.
// A 12-bit divisor D sets the oversample tick period (D cycles); every
// 16th oversample tick is also a bit tick. A change on the divisor input
// restarts all timing, and a zero divisor is flagged instead of counted.
module baud_gen (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        en_in,
  input  logic [11:0] baud_div_in,
  output logic        os_tick_out,
  output logic        bit_tick_out,
  output logic [3:0]  os_phase_out,
  output logic        div_err_out
);

  localparam int DIV_W = 12;
  localparam int PH_W  = 4;

  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_ZERO = '0;
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [PH_W-1:0]  PH_LAST  = '1;

  // Registered state and its next-state values
  logic [DIV_W-1:0] div_q, div_d;          // captured divisor
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;  // cycles within one os period
  logic [PH_W-1:0]  os_cnt_q, os_cnt_d;    // oversample phase
  logic             os_tick_q, os_tick_d;
  logic             bit_tick_q, bit_tick_d;
  logic             div_err_q, div_err_d;

  // Decoded conditions on the current state
  logic reload;     // divisor input differs from the captured copy
  logic div_zero;   // captured divisor is unusable
  logic at_term;    // last cycle of the current os period
  logic counting;   // generator is actively advancing this edge

  // Condition decode: kept separate so the next-state logic reads as a
  // straight priority list (reload, then idle/zero, then count).
  always_comb begin
    reload   = (baud_div_in != div_q);
    div_zero = (div_q == DIV_ZERO);
    // div_q - 1 wraps for a zero divisor, but at_term is only used when
    // counting, which already excludes that case.
    at_term  = (div_cnt_q == (div_q - DIV_ONE));
    counting = !reload && en_in && !div_zero;
  end

  // Next-state computation. Every path that does not count clears the
  // counters, so a partial period is never carried across a reload,
  // a disable, or a zero divisor.
  always_comb begin
    div_d      = div_q;
    div_cnt_d  = '0;
    os_cnt_d   = '0;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    // The error flag follows the divisor with one cycle of lag, so it
    // looks at the captured value before any reload lands.
    div_err_d  = div_zero;

    if (reload) begin
      div_d = baud_div_in;
    end else if (counting) begin
      if (at_term) begin
        div_cnt_d  = '0;
        os_tick_d  = 1'b1;
        os_cnt_d   = os_cnt_q + PH_ONE;
        // The bit tick marks the phase wrap 15 -> 0.
        bit_tick_d = (os_cnt_q == PH_LAST);
      end else begin
        div_cnt_d  = div_cnt_q + DIV_ONE;
        os_cnt_d   = os_cnt_q;
      end
    end
  end

  // State register with synchronous active-low reset. Reset leaves the
  // divisor at zero, so a nonzero input reloads on the first free edge.
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      div_q      <= '0;
      div_cnt_q  <= '0;
      os_cnt_q   <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      div_err_q  <= 1'b1;
    end else begin
      div_q      <= div_d;
      div_cnt_q  <= div_cnt_d;
      os_cnt_q   <= os_cnt_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      div_err_q  <= div_err_d;
    end
  end

  // All outputs come straight from flops.
  assign os_tick_out  = os_tick_q;
  assign bit_tick_out = bit_tick_q;
  assign os_phase_out = os_cnt_q;
  assign div_err_out  = div_err_q;

endmodule

// File: tb/tb_baud_gen.sv
// tb_baud_gen: directed scenarios plus a randomized phase, every cycle
// compared against an arithmetic model of the tick schedule.
module tb_baud_gen;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        en_in;
  logic [11:0] baud_div_in;
  logic        os_tick_out;
  logic        bit_tick_out;
  logic [3:0]  os_phase_out;
  logic        div_err_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: captured divisor, count of consecutive counting
  // edges since the last clear, and the error flag.
  int m_div = 0;
  int m_run = 0;
  int m_err = 1;

  int os_seen  = 0;
  int bit_seen = 0;

  baud_gen dut (
    .clk_in       (clk_in),
    .reset_n_in   (reset_n_in),
    .en_in        (en_in),
    .baud_div_in  (baud_div_in),
    .os_tick_out  (os_tick_out),
    .bit_tick_out (bit_tick_out),
    .os_phase_out (os_phase_out),
    .div_err_out  (div_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: advance the model on the edge, compare on the falling edge.
  task automatic step();
    int err_n;
    int e_os;
    int e_ph;
    int e_bit;
    @(posedge clk_in);
    if (!reset_n_in) begin
      m_div = 0;
      m_run = 0;
      m_err = 1;
    end else begin
      err_n = (m_div == 0) ? 1 : 0;
      if (int'(baud_div_in) != m_div) begin
        m_div = int'(baud_div_in);
        m_run = 0;
      end else if (!en_in || m_div == 0) begin
        m_run = 0;
      end else begin
        m_run++;
      end
      m_err = err_n;
    end
    @(negedge clk_in);
    e_os  = (m_div != 0 && m_run > 0 && (m_run % m_div) == 0) ? 1 : 0;
    e_ph  = (m_div != 0) ? ((m_run / m_div) % 16) : 0;
    e_bit = (e_os == 1 && e_ph == 0) ? 1 : 0;
    check("sb_os_tick",  int'(os_tick_out),  e_os);
    check("sb_bit_tick", int'(bit_tick_out), e_bit);
    check("sb_phase",    int'(os_phase_out), e_ph);
    check("sb_div_err",  int'(div_err_out),  m_err);
    if (os_tick_out)  os_seen++;
    if (bit_tick_out) bit_seen++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int os0;
    int bit0;
    int r;
    reset_n_in  = 1'b0;
    en_in       = 1'b0;
    baud_div_in = 12'd0;

    // Reset state
    run(3);
    check("rst_os",    int'(os_tick_out),  0);
    check("rst_bit",   int'(bit_tick_out), 0);
    check("rst_phase", int'(os_phase_out), 0);
    check("rst_err",   int'(div_err_out),  1);
    $display("reset: outputs idle, div_err=%0d", div_err_out);

    // Basic cadence, D = 325
    reset_n_in  = 1'b1;
    baud_div_in = 12'd325;
    en_in       = 1'b1;
    step();
    check("cad_reload_os", int'(os_tick_out), 0);
    run(324);
    check("cad_pre_os", int'(os_tick_out), 0);
    step();
    check("cad_first_os", int'(os_tick_out), 1);
    check("cad_first_ph", int'(os_phase_out), 1);
    run(5200 - 325 - 1);
    check("cad_pre_bit_ph", int'(os_phase_out), 15);
    check("cad_pre_bit", int'(bit_tick_out), 0);
    step();
    check("cad_bit", int'(bit_tick_out), 1);
    check("cad_bit_os", int'(os_tick_out), 1);
    check("cad_bit_ph", int'(os_phase_out), 0);
    $display("cadence D=325: bit tick at 5200 cycles");

    // Divisor change mid-count, 650 -> 2604
    baud_div_in = 12'd650;
    step();
    run(7 * 650 + 400);
    check("chg_mid_ph", int'(os_phase_out), 7);
    baud_div_in = 12'd2604;
    step();
    check("chg_reload_os", int'(os_tick_out), 0);
    check("chg_reload_ph", int'(os_phase_out), 0);
    run(2603);
    check("chg_pre_os", int'(os_tick_out), 0);
    step();
    check("chg_first_os", int'(os_tick_out), 1);
    $display("divisor change 650->2604: first tick 2604 after reload");

    // Zero divisor
    baud_div_in = 12'd0;
    step();
    check("zero_err_lag", int'(div_err_out), 0);
    step();
    check("zero_err", int'(div_err_out), 1);
    os0 = os_seen;
    run(10000);
    check("zero_no_ticks", os_seen - os0, 0);
    baud_div_in = 12'd325;
    step();
    check("zero_reload_err", int'(div_err_out), 1);
    step();
    check("zero_clear_err", int'(div_err_out), 0);
    run(323);
    check("zero_pre_os", int'(os_tick_out), 0);
    step();
    check("zero_resume_os", int'(os_tick_out), 1);
    $display("zero divisor: no ticks, error flag cleared after reload");

    // Enable gating, D = 650
    baud_div_in = 12'd650;
    step();
    run(300);
    en_in = 1'b0;
    os0 = os_seen;
    run(1000);
    check("gate_low_ph", int'(os_phase_out), 0);
    check("gate_low_ticks", os_seen - os0, 0);
    en_in = 1'b1;
    run(649);
    check("gate_pre_os", int'(os_tick_out), 0);
    step();
    check("gate_first_os", int'(os_tick_out), 1);
    $display("enable gating: first tick 650 after re-enable");

    // Minimum divisor, D = 1
    baud_div_in = 12'd1;
    step();
    os0  = os_seen;
    bit0 = bit_seen;
    step();
    check("d1_first_ph", int'(os_phase_out), 1);
    run(47);
    check("d1_os_count", os_seen - os0, 48);
    check("d1_bit_count", bit_seen - bit0, 3);
    $display("D=1: 48 os ticks, 3 bit ticks in 48 cycles");

    // Reset mid-operation, D = 1302
    baud_div_in = 12'd1302;
    step();
    run(12 * 1302);
    check("rmid_ph", int'(os_phase_out), 12);
    reset_n_in = 1'b0;
    step();
    check("rmid_os",    int'(os_tick_out),  0);
    check("rmid_bit",   int'(bit_tick_out), 0);
    check("rmid_phase", int'(os_phase_out), 0);
    check("rmid_err",   int'(div_err_out),  1);
    reset_n_in = 1'b1;
    step();
    check("rmid_reload_os", int'(os_tick_out), 0);
    run(1301);
    check("rmid_pre_os", int'(os_tick_out), 0);
    step();
    check("rmid_first_os", int'(os_tick_out), 1);
    $display("reset mid-operation: first tick 1302 after reload");

    // Randomized phase: small divisors, enable toggling, sporadic reset
    for (int c = 0; c < 6000; c++) begin
      r = int'($urandom_range(0, 999));
      if (r < 12) begin
        case ($urandom_range(0, 7))
          0: baud_div_in = 12'd0;
          1: baud_div_in = 12'd1;
          2: baud_div_in = 12'd2;
          3: baud_div_in = 12'd3;
          4: baud_div_in = 12'd5;
          5: baud_div_in = 12'd7;
          6: baud_div_in = 12'd16;
          default: baud_div_in = 12'($urandom_range(1, 40));
        endcase
      end else if (r < 30) begin
        en_in = ~en_in;
      end
      reset_n_in = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      step();
    end
    reset_n_in = 1'b1;
    $display("random phase: 6000 cycles");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
